spi_dac_arbiter: RTL and testbench
==================================

# spi_dac_arbiter

Round-robin arbiter and SPI frame sequencer that shares the single board DAC SPI link between up to NUM_REQ producers, e.g. counter12 and the test-pattern generators. Each requester offers an 8-bit sample with a valid/ready handshake. The block grants one requester at a time, latches its sample, and shifts it out MSB-first as one SPI mode-0 frame on spi_mosi/spi_clk/spi_cs. It sits directly between the producers and the top-level SPI pins.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- DIV, 50: sclk half-period and CS setup/gap length, in clk cycles; must be ≥1.
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester sample valid.
- req_data  in  8*NUM_REQ  per-requester sample; requester i occupies bits [8i+7:8i].
- req_ready  out  NUM_REQ  one-hot acceptance strobe, combinational.
- grant_id  out  3  index of the requester that owns the current or last frame; registered.
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  one-cycle pulse when a frame completes.
- spi_mosi  out  1  serial data; registered.
- spi_clk  out  1  serial clock, idle low; registered.
- spi_cs  out  1  chip select, active low; registered.

## Operation
- **State machine:** IDLE → SETUP → SHIFT → GAP → IDLE.
- **IDLE**
  - spi_cs=1, spi_clk=0, spi_mosi=0.
  - The winner is the first requester with req_valid=1, searching from pointer ptr upward modulo NUM_REQ.
  - req_ready[winner]=1 in the same cycle. All other ready bits are 0, and all are 0 when no valid is high.
  - A transfer happens on the clock edge where the winner's valid and ready are both high. On that edge:
    - latch req_data of the winner into the shift register;
    - set grant_id to the winner;
    - set ptr to winner+1 mod NUM_REQ;
    - go to SETUP.
- **SETUP** (DIV cycles): spi_cs=0, spi_clk=0, spi_mosi=bit 7.
- **SHIFT** (16 half-periods h=0..15, DIV cycles each)
  - Even h: spi_clk=1. This is the rising edge on which the DAC samples.
  - Odd h: spi_clk=0. At the start of odd h≤13, spi_mosi advances to the next lower bit.
  - spi_mosi holds bit 0 through h=14 and h=15.
- **GAP** (DIV cycles)
  - spi_cs=1, spi_clk=0, spi_mosi=0.
  - done=1 in the first GAP cycle only.
- **After GAP:** go to IDLE. Arbitration may accept in the first IDLE cycle.
- **Handshake rules**
  - Requesters must hold valid and data stable until ready.
  - In SETUP, SHIFT and GAP, req_ready is all-zero and input changes are ignored.
  - A valid that drops before acceptance loses its turn without error.
- **Width rules**
  - The divider counter is $clog2(DIV+1) bits and counts 0..DIV-1. The phase advances when count = DIV-1.
  - The half-period index is 4 bits.
- **Reset** (any state, including mid-frame)
  - The next edge forces IDLE, ptr=0, grant_id=0, divider=0, done=0, spi_cs=1, spi_clk=0, spi_mosi=0, shift register=0.
  - req_ready is forced to 0 while reset is high.
  - A truncated frame is not resumed.

## Timing
- Acceptance edge to first spi_cs low cycle: 1 cycle, because the outputs are registered.
- spi_cs low duration: 17·DIV cycles (SETUP + 16 half-periods).
- First rising spi_clk: DIV cycles after spi_cs falls. Eight rising edges per frame.
- Acceptance-to-acceptance minimum spacing: 18·DIV + 1 cycles.
- done rises on the same edge that spi_cs rises.
- Outputs change only on clk edges. spi_mosi never changes in a cycle where spi_clk rises.

## Structure
- **Shared package spi_dac_pkg**
  - State encoding: IDLE, SETUP, SHIFT, GAP.
  - FRAME_BITS=8.
  - HALF_PERIODS=16.
  - Function that computes the divider width.
- **Sub-module rr_arbiter**
  - Parameterised on NUM_REQ; holds the ptr register.
  - Produces the winner index plus a one-hot grant from req_valid and an enable (state==IDLE).
  - Advances ptr on an accept pulse.
- The top of this block holds the FSM, divider, half-period counter, shift register and output registers.

## Test plan
- **Single request:** NUM_REQ=4, DIV=2; req_valid=0001, data0=0xA5.
  - req_ready=0001 for one cycle.
  - spi_cs low for 34 cycles.
  - 8 rising spi_clk edges sampling 1,0,1,0,0,1,0,1.
  - done pulses once; grant_id=0.
- **Round-robin fairness:** valid=1111 held, each requester re-asserts after its accept.
  - Grant order 0,1,2,3,0.
  - Accept spacing exactly 37 cycles.
- **Skip and wrap:** ptr=3 after serving 2; valid=0101.
  - Winner 0, then 2.
  - No grant goes to 1 or 3.
- **Busy blocking:** requester 1 asserts valid mid-frame.
  - req_ready stays 0000 until the first IDLE cycle.
  - Then ready=0010.
  - Data changes during the frame are not transmitted.
- **Reset mid-SHIFT:** assert reset at h=5 for one cycle.
  - Next edge: spi_cs=1, spi_clk=0, spi_mosi=0, busy=0, done=0.
  - A subsequent request from requester 2 is served first, because ptr was reset to 0 and 0/1 are idle.
- **DIV=1 corner:** data 0xFF, then 0x00 back-to-back from requesters 0 and 1.
  - spi_cs low 17 cycles per frame, high 2 cycles between frames.
  - spi_mosi constant 1 during the first frame and 0 during the second.

Source files
------------

// File: rtl/spi_dac_pkg.sv
// rtl/spi_dac_pkg.sv - shared state encoding and frame constants for the DAC SPI arbiter
package spi_dac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_GAP
    } state_t;

    localparam int FRAME_BITS   = 8;
    localparam int HALF_PERIODS = 16;

    function automatic int div_width(input int div);
        return $clog2(div + 1);
    endfunction

endpackage

// File: rtl/spi_dac_arbiter_rr.sv
// rtl/spi_dac_arbiter_rr.sv - round-robin requester selection with rotating priority pointer
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic               enable,
    input  logic               accept,
    output logic [2:0]         winner,
    output logic [NUM_REQ-1:0] grant
);

    logic [2:0] ptr;
    logic [3:0] ptr_ext;
    logic       found;

    assign ptr_ext = {1'b0, ptr};

    // Scan offsets k = 0..NUM_REQ-1 from ptr; ptr+k may wrap past NUM_REQ once.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found && req_valid[i] &&
                    ((ptr_ext + 4'(k) == 4'(i)) || (ptr_ext + 4'(k) == 4'(i + NUM_REQ)))) begin
                    found  = 1'b1;
                    winner = 3'(i);
                end
            end
        end
    end

    always_comb begin
        grant = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant[i] = enable && found && (winner == 3'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (accept) begin
            ptr <= (4'(winner) + 4'd1 == 4'(NUM_REQ)) ? 3'd0 : winner + 3'd1;
        end
    end

endmodule

// File: rtl/spi_dac_arbiter.sv
// rtl/spi_dac_arbiter.sv - shares the DAC SPI link between requesters, one MSB-first mode-0 frame per grant
module spi_dac_arbiter
    import spi_dac_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DIV     = 50
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [2:0]           grant_id,
    output logic                 busy,
    output logic                 done,
    output logic                 spi_mosi,
    output logic                 spi_clk,
    output logic                 spi_cs
);

    localparam int            DW       = div_width(DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    state_t                  state;
    logic [DW-1:0]           div_cnt;
    logic [3:0]              half;
    logic [FRAME_BITS-1:0]   shreg;
    logic [2:0]              winner;
    logic [NUM_REQ-1:0]      grant;
    logic [FRAME_BITS-1:0]   win_data;
    logic                    accept;
    logic                    div_last;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .enable    ((state == ST_IDLE) && !reset),
        .accept    (accept),
        .winner    (winner),
        .grant     (grant)
    );

    assign req_ready = grant;
    assign accept    = |grant;
    assign busy      = (state != ST_IDLE);
    assign div_last  = (div_cnt == DIV_LAST);

    always_comb begin
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == 3'(i)) win_data = req_data[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            div_cnt  <= '0;
            half     <= '0;
            shreg    <= '0;
            grant_id <= '0;
            done     <= 1'b0;
            spi_cs   <= 1'b1;
            spi_clk  <= 1'b0;
            spi_mosi <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state    <= ST_SETUP;
                        shreg    <= win_data;
                        grant_id <= winner;
                        div_cnt  <= '0;
                        spi_cs   <= 1'b0;
                        spi_clk  <= 1'b0;
                        spi_mosi <= win_data[FRAME_BITS-1];
                    end
                end
                ST_SETUP: begin
                    if (div_last) begin
                        state   <= ST_SHIFT;
                        half    <= '0;
                        div_cnt <= '0;
                        spi_clk <= 1'b1;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (div_last) begin
                        div_cnt <= '0;
                        if (half == 4'(HALF_PERIODS - 1)) begin
                            state    <= ST_GAP;
                            spi_cs   <= 1'b1;
                            spi_clk  <= 1'b0;
                            spi_mosi <= 1'b0;
                            done     <= 1'b1;
                        end else begin
                            half    <= half + 4'd1;
                            spi_clk <= half[0];
                            // Data moves only on the falling half so it is stable at every rising sclk.
                            if (!half[0] && half < 4'd13) begin
                                shreg    <= {shreg[FRAME_BITS-2:0], shreg[FRAME_BITS-1]};
                                spi_mosi <= shreg[FRAME_BITS-2];
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (div_last) begin
                        state   <= ST_IDLE;
                        div_cnt <= '0;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_dac_arbiter.sv
// tb/tb_spi_dac_arbiter.sv - scoreboard bench for spi_dac_arbiter
module tb_spi_dac_arbiter;

    localparam int NREQ = 4;
    localparam int DIV  = 2;
    localparam int BUSY_CYC = 18 * DIV;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic [2:0]        grant_id;
    logic              busy, done, spi_mosi, spi_clk, spi_cs;

    logic        r1 = 1'b1;
    logic [1:0]  v1 = 2'b00;
    logic [15:0] d1 = 16'h00FF;
    logic [1:0]  rdy1;
    logic [2:0]  gid1;
    logic        busy1, done1, mosi1, sclk1, cs1;

    int checks = 0;
    int errors = 0;

    logic [NREQ-1:0] vld;
    logic [7:0]      dat [NREQ];

    int              mptr = 0, mhold = 0, mgid = 0, cyc = 0;
    logic [7:0]      cur_data = '0;
    logic [NREQ-1:0] acc_mask = '0;
    logic [10:0]     exp_q [$];
    int              log_id [$];
    int              log_t [$];
    bit              div1_done = 1'b0;

    always #5 clk = ~clk;

    spi_dac_arbiter #(.NUM_REQ(NREQ), .DIV(DIV)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .grant_id(grant_id), .busy(busy), .done(done),
        .spi_mosi(spi_mosi), .spi_clk(spi_clk), .spi_cs(spi_cs)
    );

    spi_dac_arbiter #(.NUM_REQ(2), .DIV(1)) dut1 (
        .clk(clk), .reset(r1), .req_valid(v1), .req_data(d1),
        .req_ready(rdy1), .grant_id(gid1), .busy(busy1), .done(done1),
        .spi_mosi(mosi1), .spi_clk(sclk1), .spi_cs(cs1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic drive();
        req_valid = vld;
        for (int i = 0; i < NREQ; i++) req_data[8*i +: 8] = dat[i];
    endtask

    // Reference model: frame timeline as a countdown of busy cycles after each accept.
    always @(negedge clk) begin : model
        int hb, n, h, bi, w;
        logic [NREQ-1:0] exp_rdy;
        logic e_cs, e_clk, e_mosi;
        cyc++;
        hb = mhold;
        n  = BUSY_CYC - hb + 1;
        e_cs = 1'b1; e_clk = 1'b0; e_mosi = 1'b0;
        if (hb > 0 && n <= 17 * DIV) begin
            e_cs = 1'b0;
            if (n <= DIV) begin
                e_mosi = cur_data[7];
            end else begin
                h = (n - DIV - 1) / DIV;
                e_clk = (h % 2 == 0);
                bi = (h + 1) / 2;
                if (bi > 7) bi = 7;
                e_mosi = cur_data[7 - bi];
            end
        end
        chk("spi_cs", 32'(spi_cs), 32'(e_cs));
        chk("spi_clk", 32'(spi_clk), 32'(e_clk));
        chk("spi_mosi", 32'(spi_mosi), 32'(e_mosi));
        chk("busy", 32'(busy), 32'(hb > 0));
        chk("done", 32'(done), 32'(hb == DIV));
        chk("grant_id", 32'(grant_id), 32'(mgid));
        exp_rdy  = '0;
        acc_mask = '0;
        if (reset) begin
            mptr = 0; mhold = 0; mgid = 0;
            exp_q.delete();
        end else if (hb > 0) begin
            mhold = hb - 1;
        end else begin
            w = -1;
            for (int k = 0; k < NREQ; k++)
                if (w < 0 && req_valid[(mptr + k) % NREQ]) w = (mptr + k) % NREQ;
            if (w >= 0) begin
                exp_rdy[w] = 1'b1;
                acc_mask   = exp_rdy;
                cur_data   = req_data[8*w +: 8];
                exp_q.push_back({3'(w), cur_data});
                log_id.push_back(w);
                log_t.push_back(cyc);
                mgid  = w;
                mptr  = (w + 1) % NREQ;
                mhold = BUSY_CYC;
            end
        end
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    end

    // Frame monitor: decode the SPI pins and compare each completed frame with the scoreboard.
    always @(negedge clk) begin : frame_mon
        static int fr_len = 0, fr_rise = 0;
        static logic [7:0] fr_bits = '0;
        static logic prev_clk = 1'b0, prev_mosi = 1'b0;
        logic [10:0] e;
        if (reset) begin
            fr_len = 0; fr_rise = 0; fr_bits = '0; prev_clk = 1'b0; prev_mosi = 1'b0;
        end else begin
            if (!spi_cs) begin
                fr_len++;
                if (spi_clk && !prev_clk) begin
                    fr_rise++;
                    fr_bits = {fr_bits[6:0], spi_mosi};
                    chk("mosi_stable_at_rise", 32'(spi_mosi), 32'(prev_mosi));
                end
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_frame", 32'(1), 32'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("frame_data", 32'(fr_bits), 32'(e[7:0]));
                    chk("frame_id", 32'(grant_id), 32'(e[10:8]));
                    chk("cs_low_len", 32'(fr_len), 32'(17 * DIV));
                    chk("rise_count", 32'(fr_rise), 32'(8));
                end
                fr_len = 0; fr_rise = 0; fr_bits = '0;
            end
            prev_clk  = spi_clk;
            prev_mosi = spi_mosi;
        end
    end

    task automatic step(input bit reassert, input int p_new, input int p_drop);
        @(posedge clk); #1;
        for (int i = 0; i < NREQ; i++) begin
            if (acc_mask[i]) begin
                vld[i] = reassert;
                dat[i] = 8'($urandom);
            end else if (!vld[i]) begin
                if (32'($urandom_range(99)) < 32'(p_new)) begin
                    vld[i] = 1'b1;
                    dat[i] = 8'($urandom);
                end
            end else if (mhold >= 1) begin
                if ($urandom_range(3) == 0) dat[i] = 8'($urandom);
            end else if (32'($urandom_range(99)) < 32'(p_drop)) begin
                vld[i] = 1'b0;
            end
        end
        drive();
    endtask

    task automatic wait_acc(input string name);
        for (int t = 0; t < 4 * BUSY_CYC; t++) begin
            step(1'b0, 0, 0);
            if (acc_mask != '0) return;
        end
        chk({name, "_timeout"}, 32'(1), 32'(0));
    endtask

    task automatic drain();
        vld = '0;
        drive();
        for (int t = 0; t < 4 * BUSY_CYC && mhold != 0; t++) step(1'b0, 0, 0);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
    endtask

    initial begin : main
        vld = '0;
        for (int i = 0; i < NREQ; i++) dat[i] = '0;
        drive();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_cs", 32'(spi_cs), 32'(1));
        chk("rst_clk", 32'(spi_clk), 32'(0));
        chk("rst_mosi", 32'(spi_mosi), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_gid", 32'(grant_id), 32'(0));

        // Single request 0xA5 from requester 0
        vld[0] = 1'b1; dat[0] = 8'hA5; drive();
        wait_acc("single");
        for (int c = 0; c < BUSY_CYC + 4; c++) step(1'b0, 0, 0);

        // Round-robin with all requesters re-asserting
        pulse_reset();
        log_id.delete(); log_t.delete();
        vld = '1;
        for (int i = 0; i < NREQ; i++) dat[i] = 8'($urandom);
        drive();
        for (int c = 0; c < 5 * (BUSY_CYC + 1); c++) step(1'b1, 0, 0);
        chk("rr_count", 32'(log_id.size() >= 5), 32'(1));
        for (int k = 0; k < 5 && k < log_id.size(); k++) begin
            chk("rr_order", 32'(log_id[k]), 32'(k % NREQ));
            if (k > 0) chk("rr_spacing", 32'(log_t[k] - log_t[k-1]), 32'(BUSY_CYC + 1));
        end

        // Skip and wrap: serve 2 (ptr=3), then valid=0101 gives 0 then 2
        drain();
        pulse_reset();
        vld[2] = 1'b1; dat[2] = 8'h5A; drive();
        wait_acc("skip_pre");
        drain();
        log_id.delete();
        vld[0] = 1'b1; vld[2] = 1'b1; dat[0] = 8'h11; dat[2] = 8'h22; drive();
        for (int c = 0; c < 2 * (BUSY_CYC + 1) + 4; c++) step(1'b0, 0, 0);
        chk("wrap_count", 32'(log_id.size()), 32'(2));
        if (log_id.size() == 2) begin
            chk("wrap_first", 32'(log_id[0]), 32'(0));
            chk("wrap_second", 32'(log_id[1]), 32'(2));
        end

        // Randomized traffic with drops and busy-time data scrambling
        for (int c = 0; c < 3000; c++) step(1'($urandom_range(1)), 10, 5);

        // Reset at half-period 5 of a frame, then requester 2 must win
        drain();
        vld[1] = 1'b1; dat[1] = 8'($urandom); drive();
        wait_acc("rst_frame");
        for (int c = 0; c < 6 * DIV; c++) step(1'b0, 0, 0);
        #1 reset = 1'b1; vld = '0; drive();
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_cs", 32'(spi_cs), 32'(1));
        chk("mid_rst_clk", 32'(spi_clk), 32'(0));
        chk("mid_rst_mosi", 32'(spi_mosi), 32'(0));
        chk("mid_rst_busy", 32'(busy), 32'(0));
        chk("mid_rst_done", 32'(done), 32'(0));
        vld[2] = 1'b1; dat[2] = 8'hC3; drive();
        wait_acc("post_rst");
        @(negedge clk);
        chk("post_rst_gid", 32'(grant_id), 32'(2));
        for (int c = 0; c < BUSY_CYC + 4; c++) step(1'b0, 0, 0);

        for (int t = 0; t < 1000 && !div1_done; t++) @(posedge clk);
        chk("div1_finished", 32'(div1_done), 32'(1));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // DIV=1 corner: 0xFF then 0x00 back-to-back on a second instance.
    initial begin : div1_test
        int lo [$];
        int run, hi_cnt, frames, mosi_bad;
        logic prev_cs;
        logic [1:0] rdy;
        run = 0; hi_cnt = 0; frames = 0; mosi_bad = 0; prev_cs = 1'b1;
        repeat (2) @(posedge clk);
        #1 r1 = 1'b0; v1 = 2'b11;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            rdy = rdy1;
            if (!cs1) begin
                run++;
                if (mosi1 !== ((frames == 0) ? 1'b1 : 1'b0)) mosi_bad++;
            end else begin
                if (!prev_cs) begin
                    lo.push_back(run);
                    run = 0;
                    frames++;
                end
                if (frames == 1) hi_cnt++;
            end
            prev_cs = cs1;
            @(posedge clk); #1 v1 = v1 & ~rdy;
        end
        chk("div1_frames", 32'(lo.size()), 32'(2));
        if (lo.size() == 2) begin
            chk("div1_low0", 32'(lo[0]), 32'(17));
            chk("div1_low1", 32'(lo[1]), 32'(17));
        end
        chk("div1_gap", 32'(hi_cnt), 32'(2));
        chk("div1_mosi", 32'(mosi_bad), 32'(0));
        div1_done = 1'b1;
    end

endmodule
